// File: rtl/dft_scan_unloader.sv
// Per-chain scan unload engine: rotates the chain once on request and packs the
// shifted-out bits LSB-first into 32-bit words strobed toward the output register.
module dft_scan_unloader #(
  parameter int unsigned p_chain_len = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dft_val_op,
  output logic        dft_op_ack,
  output logic        dft_op_commit,
  input  logic        dft_commit_ack,
  output logic        dft_output_strobe,
  output logic [31:0] dft_output_data,
  output logic        scan_en,
  output logic        scan_in,
  input  logic        scan_out
);

  localparam int unsigned CntW = $clog2(p_chain_len + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(p_chain_len - 1);

  typedef enum logic [1:0] {StIdle, StAck, StShift, StCommit} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic [31:0]     data_q, data_d;
  logic            strobe_q, strobe_d;
  logic            ack_q, commit_q, scan_en_q;
  logic [31:0]     word_full;

  // Chain is rotated, so the tail bit goes straight back into the head.
  assign scan_in = scan_out;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    word_d    = word_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    word_full = word_q;
    word_full[idx_q] = scan_out;

    unique case (state_q)
      StIdle: begin
        if (dft_val_op) state_d = StAck;
      end
      StAck: begin
        if (!dft_val_op) begin
          state_d = StShift;
          cnt_d   = '0;
          idx_d   = '0;
          word_d  = '0;
        end
      end
      StShift: begin
        cnt_d  = cnt_q + CntW'(1);
        idx_d  = idx_q + 5'd1;
        word_d = word_full;
        // Close the word on a full 32 bits or on the chain's final bit.
        if (idx_q == 5'd31 || cnt_q == LastBit) begin
          data_d   = word_full;
          strobe_d = 1'b1;
          idx_d    = '0;
          word_d   = '0;
        end
        if (cnt_q == LastBit) state_d = StCommit;
      end
      StCommit: begin
        if (dft_commit_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      data_q    <= '0;
      strobe_q  <= 1'b0;
      ack_q     <= 1'b0;
      commit_q  <= 1'b0;
      scan_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      // Handshake outputs are registered from the next state.
      ack_q     <= (state_d == StAck);
      commit_q  <= (state_d == StCommit);
      scan_en_q <= (state_d == StShift);
    end
  end

  assign dft_op_ack        = ack_q;
  assign dft_op_commit     = commit_q;
  assign dft_output_strobe = strobe_q;
  assign dft_output_data   = data_q;
  assign scan_en           = scan_en_q;

endmodule

// File: tb/tb_dft_scan_unloader.sv
// Self-checking bench: two chain lengths (64 and 40), table-driven and random unloads
// checked against a bit-slicing reference model, plus reset corner cases.
module tb_dft_scan_unloader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  val_op = '0;
  logic [1:0]  commit_ack = '0;
  logic [1:0]  op_ack, op_commit, strobe, scan_en, scan_in, scan_out;
  logic [31:0] data0, data1;
  logic [63:0] chain64 = '0;
  logic [39:0] chain40 = '0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dft_scan_unloader #(.p_chain_len(64)) u_dut64 (
    .clk               (clk),
    .reset             (reset),
    .dft_val_op        (val_op[0]),
    .dft_op_ack        (op_ack[0]),
    .dft_op_commit     (op_commit[0]),
    .dft_commit_ack    (commit_ack[0]),
    .dft_output_strobe (strobe[0]),
    .dft_output_data   (data0),
    .scan_en           (scan_en[0]),
    .scan_in           (scan_in[0]),
    .scan_out          (scan_out[0])
  );

  dft_scan_unloader #(.p_chain_len(40)) u_dut40 (
    .clk               (clk),
    .reset             (reset),
    .dft_val_op        (val_op[1]),
    .dft_op_ack        (op_ack[1]),
    .dft_op_commit     (op_commit[1]),
    .dft_commit_ack    (commit_ack[1]),
    .dft_output_strobe (strobe[1]),
    .dft_output_data   (data1),
    .scan_en           (scan_en[1]),
    .scan_in           (scan_in[1]),
    .scan_out          (scan_out[1])
  );

  // Behavioural scan chains; tail (bit 0) drives scan_out.
  assign scan_out[0] = chain64[0];
  assign scan_out[1] = chain40[0];

  always @(posedge clk) begin
    if (scan_en[0]) chain64 <= {scan_in[0], chain64[63:1]};
    if (scan_en[1]) chain40 <= {scan_in[1], chain40[39:1]};
  end

  typedef struct {
    int          sel;
    logic [63:0] pre;
    int          hold;
    int          cwait;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] get_data(input int sel);
    return (sel == 0) ? data0 : data1;
  endfunction

  function automatic logic [63:0] get_chain(input int sel);
    return (sel == 0) ? chain64 : {24'h0, chain40};
  endfunction

  // Reference: word w holds chain bits [32w+31:32w], zero beyond the chain length.
  function automatic logic [31:0] model_word(input logic [63:0] pre, input int len, input int w);
    logic [31:0] r = '0;
    for (int b = 0; b < 32; b++) if (32 * w + b < len) r[b] = pre[32 * w + b];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int sel, input logic [63:0] pre, input int hold, input int cwait,
                        input logic [31:0] w0, input logic [31:0] w1);
    int          len = (sel == 0) ? 64 : 40;
    int          c = 0;
    int          en_cnt = 0;
    int          n_strobe = 0;
    int          first_c = -1;
    int          last_c = -1;
    int          commit_c = -1;
    int          ack_cnt = 0;
    int          early_en = 0;
    logic [31:0] words[2];
    words[0] = '0;
    words[1] = '0;
    if (sel == 0) chain64 <= pre;
    else chain40 <= pre[39:0];
    #1;
    val_op[sel] = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (op_ack[sel]) ack_cnt++;
      if (scan_en[sel]) early_en++;
    end
    val_op[sel] = 1'b0;
    check("ack_held_cycles", 64'(ack_cnt), 64'(hold));
    check("no_scan_en_while_ack", 64'(early_en), 64'd0);
    while (commit_c < 0 && c < len + 40) begin
      tick();
      c++;
      if (c == 1) check("ack_dropped", 64'(op_ack[sel]), 64'd0);
      if (scan_en[sel]) en_cnt++;
      if (strobe[sel]) begin
        if (n_strobe < 2) words[n_strobe] = get_data(sel);
        if (first_c < 0) first_c = c;
        last_c = c;
        n_strobe++;
      end
      if (op_commit[sel]) commit_c = c;
    end
    check("commit_cycle", 64'(commit_c), 64'(len + 1));
    check("scan_en_cycles", 64'(en_cnt), 64'(len));
    check("strobe_count", 64'(n_strobe), 64'd2);
    check("first_strobe_cycle", 64'(first_c), 64'(33));
    check("last_strobe_cycle", 64'(last_c), 64'(len + 1));
    check("word0", 64'(words[0]), 64'(w0));
    check("word1", 64'(words[1]), 64'(w1));
    for (int i = 0; i < cwait; i++) begin
      tick();
      check("commit_held", 64'({op_commit[sel], strobe[sel]}), 64'b10);
    end
    commit_ack[sel] = 1'b1;
    tick();
    commit_ack[sel] = 1'b0;
    check("commit_released", 64'(op_commit[sel]), 64'd0);
    check("data_holds", 64'(get_data(sel)), 64'(w1));
    check("chain_restored", get_chain(sel), pre & ((sel == 0) ? ~64'h0 : 64'hFF_FFFF_FFFF));
  endtask

  initial begin
    logic [63:0] pre;
    int          sel;
    int          len;
    int          bad;

    vecs[0] = '{0, 64'hDEADBEEF_01234567, 1, 0,  32'h01234567, 32'hDEADBEEF};
    vecs[1] = '{1, 64'h000000A5_FFFF0000, 1, 0,  32'hFFFF0000, 32'h000000A5};
    vecs[2] = '{0, 64'hDEADBEEF_01234567, 5, 10, 32'h01234567, 32'hDEADBEEF};
    vecs[3] = '{1, 64'h00000012_3456789A, 3, 2,  32'h3456789A, 32'h00000012};

    // Reset values while reset held.
    #2;
    check("reset_outputs", {op_ack, op_commit, strobe, scan_en}, 64'd0);
    check("reset_data", {data0, data1}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_op(vecs[i].sel, vecs[i].pre, vecs[i].hold, vecs[i].cwait,
                             vecs[i].w0, vecs[i].w1);
    // Second unload of same chain returns same data.
    run_op(0, chain64, 1, 0, 32'h01234567, 32'hDEADBEEF);

    for (int t = 0; t < 6; t++) begin
      sel = int'($urandom_range(0, 1));
      len = (sel == 0) ? 64 : 40;
      pre = {$urandom, $urandom};
      if (sel == 1) pre[63:40] = '0;
      run_op(sel, pre, int'($urandom_range(1, 4)), int'($urandom_range(0, 5)),
             model_word(pre, len, 0), model_word(pre, len, 1));
    end

    // Asynchronous reset in the middle of a shift.
    chain64 <= 64'h0F0F_1234_5678_9ABC;
    #1;
    val_op[0] = 1'b1;
    tick();
    val_op[0] = 1'b0;
    bad = 1;
    for (int i = 0; i < 60 && bad != 0; i++) begin
      tick();
      if (scan_en[0]) bad++;
      if (bad == 21) bad = 0;
    end
    check("reached_20_shifts", 64'(bad), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("midshift_reset_outputs", {op_ack[0], op_commit[0], strobe[0], scan_en[0]}, 64'd0);
    check("midshift_reset_data", 64'(data0), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (strobe[0] || op_commit[0] || scan_en[0] || op_ack[0]) bad++;
    end
    check("quiet_after_reset", 64'(bad), 64'd0);
    pre = chain64;
    run_op(0, pre, 2, 1, model_word(pre, 64, 0), model_word(pre, 64, 1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
